serial_adder_nb: RTL and testbench

Bit-serial N-bit adder/subtractor. It sums two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a registered carry. A start/busy/done handshake frames each operation. It is the parametrised, sequential successor of the 1-bit full adder and is used inside the FSM datapath wherever area matters more than latency.

---
 rtl/serial_adder_nb.sv | 118 +++++++++++
 tb/tb_serial_adder_nb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_nb.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first,
// framed by a start/busy/done handshake.
module serial_adder_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             bit_s, bit_c, last;

    always_comb begin
        bit_s   = opa_q[0] ^ opb_q[0] ^ carry_q;
        bit_c   = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q)
                | (opb_q[0] & carry_q);
        last    = (cnt_q == CW'(WIDTH - 1));
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift right so bit i is always at position 0.
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = bit_c;
                res_d   = res_q >> 1;
                res_d[WIDTH-1] = bit_s;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = res_d;
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_nb.sv
// Self-checking bench for serial_adder_nb at WIDTH=8 and WIDTH=1.
module tb_serial_adder_nb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s8, c8i, sb8, co8, ov8, bz8, dn8;
    logic [7:0] a8, b8, sum8;
    logic       s1, c1i, sb1, co1, ov1, bz1, dn1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int failures = 0;

    serial_adder_nb #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .cin(c8i), .sub(sb8), .sum(sum8), .cout(co8),
        .overflow(ov8), .busy(bz8), .done(dn8)
    );

    serial_adder_nb #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
        .cin(c1i), .sub(sb1), .sum(sum1), .cout(co1),
        .overflow(ov1), .busy(bz1), .done(dn1)
    );

    // Arithmetic reference: plain integer add/subtract and signed range test.
    function automatic void model(input int w, input int a, input int b,
                                  input int cin, input int sub,
                                  output int s, output int co, output int ov);
        int m, h, t, sa, sbv, r;
        m = (1 << w) - 1;
        h = 1 << (w - 1);
        if (sub != 0) begin
            t  = a - b - cin;
            co = (t >= 0) ? 1 : 0;
        end else begin
            t  = a + b + cin;
            co = (t >> w) & 1;
        end
        s   = t & m;
        sa  = (a >= h) ? a - (1 << w) : a;
        sbv = (b >= h) ? b - (1 << w) : b;
        r   = (sub != 0) ? sa - sbv - cin : sa + sbv + cin;
        ov  = (r < -h || r > h - 1) ? 1 : 0;
    endfunction

    // Runs one operation; reports results, busy length and protocol errors.
    task automatic do_op(input bit w1, input int a, input int b,
                         input int cin, input int sub,
                         output int s, output int co, output int ov,
                         output int nbusy, output bit seen, output bit bad);
        logic [7:0] hold, cur;
        logic bz, dn;
        @(negedge clk);
        if (w1) begin
            s1 = 1; a1 = a[0:0]; b1 = b[0:0]; c1i = cin[0]; sb1 = sub[0];
            hold = {7'b0, sum1};
        end else begin
            s8 = 1; a8 = a[7:0]; b8 = b[7:0]; c8i = cin[0]; sb8 = sub[0];
            hold = sum8;
        end
        @(negedge clk);
        s1 = 0; s8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom);
        c8i = 1'($urandom); sb8 = 1'($urandom);
        c1i = 1'($urandom); sb1 = 1'($urandom);
        nbusy = 0; seen = 0; bad = 0; s = 0; co = 0; ov = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            bz  = w1 ? bz1 : bz8;
            dn  = w1 ? dn1 : dn8;
            cur = w1 ? {7'b0, sum1} : sum8;
            if (bz && dn) bad = 1;
            if (bz) begin
                nbusy++;
                if (cur !== hold) bad = 1;
            end
            if (dn) begin
                seen = 1;
                s  = int'(cur);
                co = w1 ? int'(co1) : int'(co8);
                ov = w1 ? int'(ov1) : int'(ov8);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        if ((w1 ? dn1 : dn8) !== 1'b0) bad = 1;
    endtask

    task automatic test_reset();
        rst = 1; s8 = 1; s1 = 0;
        a8 = 8'h11; b8 = 8'h22; c8i = 0; sb8 = 0;
        a1 = 0; b1 = 0; c1i = 0; sb1 = 0;
        @(negedge clk);
        checks++;
        if ({sum8, co8, ov8, bz8, dn8} !== 12'h0) begin
            failures++;
            $display("FAIL reset_out8 got=%h exp=0",
                     {sum8, co8, ov8, bz8, dn8});
        end
        checks++;
        if ({sum1, co1, ov1, bz1, dn1} !== 5'h0) begin
            failures++;
            $display("FAIL reset_out1 got=%h exp=0",
                     {sum1, co1, ov1, bz1, dn1});
        end
        rst = 0;
        @(negedge clk);
        s8 = 0;
        checks++;
        if (bz8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_start_held busy got=%b exp=1", bz8);
        end
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (dn8) seen = 1;
            end
            checks++;
            if (!seen || sum8 !== 8'h33) begin
                failures++;
                $display("FAIL reset_first_op done=%b sum=%h exp=33",
                         seen, sum8);
            end
        end
    endtask

    task automatic test_directed();
        int ta[5]  = '{'h5A, 'hFF, 'hFF, 'h10, 'h80};
        int tb[5]  = '{'h3C, 'h01, 'h01, 'h20, 'h01};
        int tc[5]  = '{0, 0, 1, 0, 0};
        int tsb[5] = '{0, 0, 0, 1, 1};
        int es[5]  = '{'h96, 'h00, 'h01, 'hF0, 'h7F};
        int eco[5] = '{0, 1, 1, 0, 1};
        int eov[5] = '{1, 0, 0, 0, 1};
        int s, co, ov, nb;
        bit seen, bad;
        for (int i = 0; i < 5; i++) begin
            do_op(0, ta[i], tb[i], tc[i], tsb[i], s, co, ov, nb, seen, bad);
            checks++;
            if (s != es[i]) begin
                failures++;
                $display("FAIL dir_sum[%0d] got=%h exp=%h", i, s, es[i]);
            end
            checks++;
            if (co != eco[i]) begin
                failures++;
                $display("FAIL dir_cout[%0d] got=%0d exp=%0d", i, co, eco[i]);
            end
            checks++;
            if (ov != eov[i]) begin
                failures++;
                $display("FAIL dir_ovf[%0d] got=%0d exp=%0d", i, ov, eov[i]);
            end
            checks++;
            if (nb != 8) begin
                failures++;
                $display("FAIL dir_busy[%0d] got=%0d exp=8", i, nb);
            end
            checks++;
            if (!seen || bad) begin
                failures++;
                $display("FAIL dir_proto[%0d] seen=%b bad=%b exp seen=1 bad=0",
                         i, seen, bad);
            end
        end
    endtask

    task automatic test_random();
        int a, b, c, sb, s, co, ov, nb, es, eco, eov;
        bit seen, bad;
        for (int i = 0; i < 16; i++) begin
            a  = int'($urandom_range(255));
            b  = int'($urandom_range(255));
            c  = int'($urandom_range(1));
            sb = int'($urandom_range(1));
            model(8, a, b, c, sb, es, eco, eov);
            do_op(0, a, b, c, sb, s, co, ov, nb, seen, bad);
            checks++;
            if (s != es || co != eco || ov != eov || nb != 8 || !seen || bad) begin
                failures++;
                $display("FAIL rnd[%0d] a=%h b=%h cin=%0d sub=%0d got=%h/%0d/%0d busy=%0d seen=%b bad=%b exp=%h/%0d/%0d busy=8",
                         i, a, b, c, sb, s, co, ov, nb, seen, bad, es, eco, eov);
            end
        end
    endtask

    task automatic test_back_to_back();
        int va[30], vb[30], vc[30], vs[30];
        int es, eco, eov, last_s;
        bit have;
        have = 0; last_s = 0;
        for (int c = 0; c < 30; c++) begin
            s8  = 1;
            va[c] = int'($urandom_range(255));
            vb[c] = int'($urandom_range(255));
            vc[c] = int'($urandom_range(1));
            vs[c] = int'($urandom_range(1));
            a8 = va[c][7:0]; b8 = vb[c][7:0];
            c8i = vc[c][0]; sb8 = vs[c][0];
            @(negedge clk);
            checks++;
            if (dn8 !== ((c % 10) == 8) || bz8 !== ((c % 10) < 8)) begin
                failures++;
                $display("FAIL b2b_frame[%0d] done=%b busy=%b exp done=%b busy=%b",
                         c, dn8, bz8, (c % 10) == 8, (c % 10) < 8);
            end
            if ((c % 10) == 8) begin
                model(8, va[c-8], vb[c-8], vc[c-8], vs[c-8], es, eco, eov);
                last_s = es;
                have = 1;
                checks++;
                if (int'(sum8) != es || int'(co8) != eco || int'(ov8) != eov) begin
                    failures++;
                    $display("FAIL b2b_result[%0d] got=%h/%b/%b exp=%h/%0d/%0d",
                             c, sum8, co8, ov8, es, eco, eov);
                end
            end else if (have) begin
                checks++;
                if (int'(sum8) != last_s) begin
                    failures++;
                    $display("FAIL b2b_hold[%0d] got=%h exp=%h", c, sum8, last_s);
                end
            end
        end
        s8 = 0;
    endtask

    task automatic test_reset_mid_run();
        int s, co, ov, nb;
        bit seen, bad, any_done;
        @(negedge clk);
        s8 = 1; a8 = 8'h5A; b8 = 8'h3C; c8i = 0; sb8 = 0;
        @(negedge clk);
        s8 = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({sum8, co8, ov8, bz8, dn8} !== 12'h0) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=0", {sum8, co8, ov8, bz8, dn8});
        end
        @(negedge clk);
        rst = 0;
        any_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn8 || bz8) any_done = 1;
        end
        checks++;
        if (any_done) begin
            failures++;
            $display("FAIL midrun_no_done got=1 exp=0");
        end
        do_op(0, 1, 1, 0, 0, s, co, ov, nb, seen, bad);
        checks++;
        if (s != 2 || co != 0 || ov != 0 || nb != 8 || !seen || bad) begin
            failures++;
            $display("FAIL midrun_after got=%h/%0d/%0d busy=%0d seen=%b bad=%b exp=02/0/0 busy=8",
                     s, co, ov, nb, seen, bad);
        end
    endtask

    task automatic test_width1();
        int a, b, c, s, co, ov, nb, es, eco;
        bit seen, bad;
        for (int i = 0; i < 8; i++) begin
            a = i & 1; b = (i >> 1) & 1; c = (i >> 2) & 1;
            es  = (a + b + c) % 2;
            eco = (a + b + c) / 2;
            do_op(1, a, b, c, 0, s, co, ov, nb, seen, bad);
            checks++;
            if (s != es || co != eco || ov != (c ^ eco) || nb != 1 || !seen || bad) begin
                failures++;
                $display("FAIL w1[%0d] got=%0d/%0d/%0d busy=%0d seen=%b bad=%b exp=%0d/%0d/%0d busy=1",
                         i, s, co, ov, nb, seen, bad, es, eco, c ^ eco);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
